pacman_game_fsm: RTL and testbench
==================================

PACMAN_GAME_FSM -- requirements
Module: pacman_game_fsm

Interface
REQ-001 SHALL have parameter N_GHOSTS, default 3: width of the ghost_hit vector (1..8).
REQ-002 SHALL have parameter LIVES_INIT, default 3: lives loaded at game start (1..7).
REQ-003 SHALL have parameter READY_FRAMES, default 60: frame ticks spent in READY.
REQ-004 SHALL have parameter DEATH_FRAMES, default 10: frame ticks spent in DYING and in CLEAR.
REQ-005 SHALL have parameter DOT_COUNT, default 240: dots per level (1..1023).
REQ-006 SHALL have parameter DOT_POINTS, default 10: score added per dot.
REQ-007 SHALL have parameter SCORE_W, default 16: score width.
REQ-008 SHALL have parameter EXTRA_LIFE_SCORE, default 10000: bonus threshold, used only under REQ-033.
REQ-009 clk  in  1  single system clock (25 MHz pixel clock); all logic on its rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 frame_tick  in  1  one-cycle pulse per video frame.
REQ-012 start_btn  in  1  level-sensitive start request.
REQ-013 ghost_hit  in  N_GHOSTS  per-ghost collision flags, OR-reduced.
REQ-014 dot_eaten  in  1  one-cycle pulse per dot consumed.
REQ-015 soft_reset  out  1  holds player, ghosts and dots at their start positions.
REQ-016 play_en  out  1  high only while in PLAY.
REQ-017 state  out  3  READY=0, PLAY=1, DYING=2, CLEAR=3, OVER=4.
REQ-018 lives  out  3  remaining lives; score  out  SCORE_W  points; level  out  4  completed-level count.

Function
REQ-019 All outputs and state SHALL be registered; each transition SHALL take effect on the clock edge that samples its qualifying input (1-cycle latency to outputs).
REQ-020 An internal frame counter SHALL count frame_tick pulses, clear on every state entry, and be wide enough for max(READY_FRAMES, DEATH_FRAMES).
REQ-021 READY: soft_reset=1, play_en=0; on the frame_tick that makes the counter equal READY_FRAMES, go to PLAY.
REQ-022 PLAY: soft_reset=0, play_en=1; dot_eaten SHALL add DOT_POINTS to score, saturating at all-ones, and decrement dots_left.
REQ-023 PLAY: any ghost_hit bit high SHALL cause a transition to DYING, decrementing lives, saturating at 0.
REQ-024 PLAY: the dot_eaten that brings dots_left to 0 SHALL cause a transition to CLEAR.
REQ-025 A ghost hit and the last dot in the same cycle SHALL score the dot and enter DYING; hit has priority.
REQ-026 DYING: soft_reset=1 on entry; after DEATH_FRAMES ticks go to OVER if lives=0, else CLEAR if dots_left=0, else READY.
REQ-027 CLEAR: soft_reset=1; after DEATH_FRAMES ticks, increment level (15 wraps to 0), reload dots_left=DOT_COUNT and go to READY.
REQ-028 OVER: soft_reset=1, play_en=0, outputs frozen; start_btn=1 SHALL re-initialise lives, score, level, dots_left and go to READY.
REQ-029 ghost_hit and dot_eaten SHALL be ignored in every state except PLAY; start_btn SHALL be ignored except in OVER.
REQ-030 Unused state encodings 5..7 SHALL return to READY on the next clock.

Reset
REQ-031 rst=1 at any clock edge, including mid-DYING or mid-CLEAR, SHALL set state=READY, soft_reset=1, play_en=0, lives=LIVES_INIT, score=0, level=0, dots_left=DOT_COUNT, frame counter=0 and bonus flag=0; rst overrides all other inputs.

Configuration
REQ-032 Without macro PACMAN_EXTRA_LIFE_EN: no bonus logic; lives only decrements or reloads.
REQ-033 With PACMAN_EXTRA_LIFE_EN: the first time in a game that score becomes >= EXTRA_LIFE_SCORE, lives SHALL increment once, saturating at 7; a bonus flag blocks repeats and clears on game start.

Verification
REQ-034 rst pulse, then 60 frame_ticks -> state 0 through tick 59, state=1 and play_en=1 the cycle after tick 60.
REQ-035 In PLAY, LIVES_INIT=3, ghost_hit=3'b010 for 1 cycle -> state=2, lives=2; 10 ticks later -> state=0.
REQ-036 DOT_COUNT=4, 4 dot_eaten pulses -> score=40, state=3; after 10 ticks -> level=1, state=0, dots_left=4.
REQ-037 Last dot and ghost_hit in the same cycle with lives=1 -> score incremented, lives=0, state=2, then state=4; start_btn -> state=0, score=0, lives=3.
REQ-038 With PACMAN_EXTRA_LIFE_EN, DOT_POINTS=5000, two dots -> lives rises 3 to 4 once; a third dot causes no further increment. Without the macro, lives stays 3.
REQ-039 rst asserted mid-DYING, plus dot_eaten pulses applied in READY -> all outputs at reset values; score unchanged by the ignored pulses.

Source files
------------

// File: rtl/pacman_game_fsm.sv
// Pac-Man game-flow controller: sequences READY/PLAY/DYING/CLEAR/OVER and keeps score, lives and level.
// Optional feature: define PACMAN_EXTRA_LIFE_EN to award one bonus life per game at EXTRA_LIFE_SCORE.
module pacman_game_fsm #(
    parameter int N_GHOSTS         = 3,
    parameter int LIVES_INIT       = 3,
    parameter int READY_FRAMES     = 60,
    parameter int DEATH_FRAMES     = 10,
    parameter int DOT_COUNT        = 240,
    parameter int DOT_POINTS       = 10,
    parameter int SCORE_W          = 16,
    parameter int EXTRA_LIFE_SCORE = 10000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                start_btn,
    input  logic [N_GHOSTS-1:0] ghost_hit,
    input  logic                dot_eaten,
    output logic                soft_reset,
    output logic                play_en,
    output logic [2:0]          state,
    output logic [2:0]          lives,
    output logic [SCORE_W-1:0]  score,
    output logic [3:0]          level
);

    localparam int FRAME_MAX = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
    localparam int FRAME_W   = (FRAME_MAX < 1) ? 1 : $clog2(FRAME_MAX + 1);

    localparam logic [FRAME_W-1:0] READY_LIM = FRAME_W'(READY_FRAMES);
    localparam logic [FRAME_W-1:0] DEATH_LIM = FRAME_W'(DEATH_FRAMES);
    localparam logic [9:0]         DOTS_INIT = 10'(DOT_COUNT);
    localparam logic [2:0]         LIVES_RST = 3'(LIVES_INIT);
    localparam logic [SCORE_W:0]   DOT_ADD   = (SCORE_W + 1)'(DOT_POINTS);

    typedef enum logic [2:0] {
        ST_READY = 3'd0,
        ST_PLAY  = 3'd1,
        ST_DYING = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [2:0]           lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           level_q, level_d;
    logic [9:0]           dots_q, dots_d;
    logic                 soft_reset_q, soft_reset_d;
    logic                 play_en_q, play_en_d;

    logic                 hit;
    logic [FRAME_W-1:0]   frame_inc;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;

`ifdef PACMAN_EXTRA_LIFE_EN
    localparam logic [SCORE_W-1:0] EXTRA_THR = SCORE_W'(EXTRA_LIFE_SCORE);
    logic                 bonus_q, bonus_d;
`endif

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        lives_d   = lives_q;
        score_d   = score_q;
        level_d   = level_q;
        dots_d    = dots_q;
`ifdef PACMAN_EXTRA_LIFE_EN
        bonus_d   = bonus_q;
`endif
        hit       = |ghost_hit;
        frame_inc = frame_q + 1'b1;
        score_sum = {1'b0, score_q} + DOT_ADD;
        score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

        case (state_q)
            ST_READY: begin
                if (frame_tick) begin
                    frame_d = frame_inc;
                    if (frame_inc == READY_LIM) begin
                        state_d = ST_PLAY;
                        frame_d = '0;
                    end
                end
            end
            ST_PLAY: begin
                if (dot_eaten) begin
                    score_d = score_sat;
                    if (dots_q != 10'd0)
                        dots_d = dots_q - 10'd1;
                end
                // A hit outranks clearing the level with the same dot.
                if (hit) begin
                    lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    state_d = ST_DYING;
                    frame_d = '0;
                end else if (dot_eaten && dots_q <= 10'd1) begin
                    state_d = ST_CLEAR;
                    frame_d = '0;
                end
`ifdef PACMAN_EXTRA_LIFE_EN
                if (dot_eaten && !bonus_q && score_sat >= EXTRA_THR) begin
                    bonus_d = 1'b1;
                    lives_d = (lives_d == 3'd7) ? 3'd7 : lives_d + 3'd1;
                end
`endif
            end
            ST_DYING: begin
                if (frame_tick) begin
                    frame_d = frame_inc;
                    if (frame_inc == DEATH_LIM) begin
                        frame_d = '0;
                        if (lives_q == 3'd0)
                            state_d = ST_OVER;
                        else if (dots_q == 10'd0)
                            state_d = ST_CLEAR;
                        else
                            state_d = ST_READY;
                    end
                end
            end
            ST_CLEAR: begin
                if (frame_tick) begin
                    frame_d = frame_inc;
                    if (frame_inc == DEATH_LIM) begin
                        frame_d = '0;
                        level_d = level_q + 4'd1;
                        dots_d  = DOTS_INIT;
                        state_d = ST_READY;
                    end
                end
            end
            ST_OVER: begin
                if (start_btn) begin
                    lives_d = LIVES_RST;
                    score_d = '0;
                    level_d = 4'd0;
                    dots_d  = DOTS_INIT;
`ifdef PACMAN_EXTRA_LIFE_EN
                    bonus_d = 1'b0;
`endif
                    state_d = ST_READY;
                    frame_d = '0;
                end
            end
            default: begin
                state_d = ST_READY;
                frame_d = '0;
            end
        endcase

        soft_reset_d = (state_d != ST_PLAY);
        play_en_d    = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_READY;
            frame_q      <= '0;
            lives_q      <= LIVES_RST;
            score_q      <= '0;
            level_q      <= 4'd0;
            dots_q       <= DOTS_INIT;
            soft_reset_q <= 1'b1;
            play_en_q    <= 1'b0;
`ifdef PACMAN_EXTRA_LIFE_EN
            bonus_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            level_q      <= level_d;
            dots_q       <= dots_d;
            soft_reset_q <= soft_reset_d;
            play_en_q    <= play_en_d;
`ifdef PACMAN_EXTRA_LIFE_EN
            bonus_q      <= bonus_d;
`endif
        end
    end

    assign soft_reset = soft_reset_q;
    assign play_en    = play_en_q;
    assign state      = state_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign level      = level_q;

endmodule

// File: tb/tb_pacman_game_fsm.sv
// Bench for pacman_game_fsm: directed scenarios plus random play, every cycle compared with a rule-level game model.
module tb_pacman_game_fsm;

    localparam int N_GH   = 3;
    localparam int L_INIT = 3;
    localparam int R_FR   = 60;
    localparam int D_FR   = 10;
    localparam int DOTS   = 4;
    localparam int PTS    = 10;
    localparam int SW     = 8;
    localparam int XTRA   = 200;
    localparam int SMAX   = (1 << SW) - 1;

    localparam int READY = 0, PLAY = 1, DYING = 2, CLEAR = 3, OVER = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frame_tick = 1'b0;
    logic            start_btn = 1'b0;
    logic [N_GH-1:0] ghost_hit = '0;
    logic            dot_eaten = 1'b0;
    logic            soft_reset, play_en;
    logic [2:0]      state, lives;
    logic [SW-1:0]   score;
    logic [3:0]      level;

    int checks = 0;
    int errors = 0;

    // Game model: plain integers following the game rules.
    int m_phase, m_lives, m_score, m_level, m_dots, m_frames, m_bonus;

    pacman_game_fsm #(
        .N_GHOSTS(N_GH), .LIVES_INIT(L_INIT), .READY_FRAMES(R_FR), .DEATH_FRAMES(D_FR),
        .DOT_COUNT(DOTS), .DOT_POINTS(PTS), .SCORE_W(SW), .EXTRA_LIFE_SCORE(XTRA)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
        .ghost_hit(ghost_hit), .dot_eaten(dot_eaten), .soft_reset(soft_reset),
        .play_en(play_en), .state(state), .lives(lives), .score(score), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic new_game();
        m_lives = L_INIT; m_score = 0; m_level = 0; m_dots = DOTS; m_bonus = 0;
    endtask

    task automatic go_to(int ph);
        m_phase = ph; m_frames = 0;
    endtask

    task automatic model_step(bit r, bit tick, bit start, bit hit, bit dot);
        if (r) begin
            new_game(); go_to(READY);
            return;
        end
        if (m_phase != PLAY && m_phase != OVER && tick) m_frames++;
        case (m_phase)
            READY: if (m_frames == R_FR) go_to(PLAY);
            PLAY: begin
                if (dot) begin
                    m_score = (m_score + PTS > SMAX) ? SMAX : m_score + PTS;
                    if (m_dots > 0) m_dots--;
                end
                if (hit) begin
                    if (m_lives > 0) m_lives--;
                    go_to(DYING);
                end else if (dot && m_dots == 0) begin
                    go_to(CLEAR);
                end
`ifdef PACMAN_EXTRA_LIFE_EN
                if (dot && m_bonus == 0 && m_score >= XTRA) begin
                    m_bonus = 1;
                    if (m_lives < 7) m_lives++;
                end
`endif
            end
            DYING: if (m_frames == D_FR) begin
                if (m_lives == 0) go_to(OVER);
                else if (m_dots == 0) go_to(CLEAR);
                else go_to(READY);
            end
            CLEAR: if (m_frames == D_FR) begin
                m_level = (m_level + 1) % 16;
                m_dots = DOTS;
                go_to(READY);
            end
            default: if (start) begin
                new_game(); go_to(READY);
            end
        endcase
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare everything.
    task automatic cyc(bit r, bit tick, bit start, logic [N_GH-1:0] gh, bit dot);
        rst = r; frame_tick = tick; start_btn = start; ghost_hit = gh; dot_eaten = dot;
        @(posedge clk);
        model_step(r, tick, start, |gh, dot);
        #1;
        chk("state", int'(state), m_phase);
        chk("lives", int'(lives), m_lives);
        chk("score", int'(score), m_score);
        chk("level", int'(level), m_level);
        chk("soft_reset", int'(soft_reset), (m_phase != PLAY) ? 1 : 0);
        chk("play_en", int'(play_en), (m_phase == PLAY) ? 1 : 0);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, '0, 0);
            cyc(0, 0, 0, '0, 0);
        end
    endtask

    task automatic ready_to_play();
        for (int i = 1; i <= R_FR; i++) begin
            cyc(0, 1, 0, '0, 0);
            chk("ready_wait", int'(state), (i < R_FR) ? READY : PLAY);
            cyc(0, 0, 0, '0, 0);
        end
    endtask

    initial begin
        new_game(); go_to(READY);
        cyc(1, 0, 0, '0, 0);
        cyc(1, 1, 1, 3'b111, 1);
        chk("rst_state", int'(state), READY);
        chk("rst_lives", int'(lives), L_INIT);
        chk("rst_score", int'(score), 0);
        chk("rst_soft", int'(soft_reset), 1);
        $display("txn reset: state=%0d lives=%0d score=%0d", state, lives, score);

        ready_to_play();
        chk("play_en_up", int'(play_en), 1);
        $display("txn ready->play: state=%0d play_en=%0d", state, play_en);

        cyc(0, 0, 0, 3'b010, 0);
        chk("hit_state", int'(state), DYING);
        chk("hit_lives", int'(lives), 2);
        ticks(D_FR);
        chk("dying_done", int'(state), READY);
        $display("txn ghost hit: lives=%0d state=%0d", lives, state);

        ready_to_play();
        for (int i = 0; i < DOTS; i++) cyc(0, 0, 0, '0, 1);
        chk("clear_score", int'(score), 40);
        chk("clear_state", int'(state), CLEAR);
        ticks(D_FR);
        chk("clear_level", int'(level), 1);
        chk("clear_ready", int'(state), READY);
        $display("txn level clear: score=%0d level=%0d", score, level);

        // Dots reloaded to 4: three dots, then die with one left.
        ready_to_play();
        for (int i = 0; i < DOTS - 1; i++) cyc(0, 0, 0, '0, 1);
        chk("reload_play", int'(state), PLAY);
        cyc(0, 0, 0, 3'b001, 0);
        ticks(D_FR);
        chk("lives_one", int'(lives), 1);
        ready_to_play();
        cyc(0, 0, 0, 3'b100, 1);
        chk("tie_score", int'(score), 80);
        chk("tie_lives", int'(lives), 0);
        chk("tie_state", int'(state), DYING);
        ticks(D_FR);
        chk("over_state", int'(state), OVER);
        cyc(0, 1, 0, 3'b111, 1);
        chk("over_frozen", int'(score), 80);
        cyc(0, 0, 1, '0, 0);
        chk("restart_state", int'(state), READY);
        chk("restart_score", int'(score), 0);
        chk("restart_lives", int'(lives), L_INIT);
        $display("txn game over/restart: state=%0d score=%0d lives=%0d", state, score, lives);

        // Reset in the middle of DYING, then dots while READY must not score.
        ready_to_play();
        cyc(0, 0, 0, 3'b010, 0);
        ticks(3);
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 3'b111, 1);
        chk("midrst_state", int'(state), READY);
        chk("midrst_score", int'(score), 0);
        chk("midrst_lives", int'(lives), L_INIT);
        $display("txn reset mid-dying: state=%0d score=%0d", state, score);

        // Seventeen clean levels: score saturates and level wraps past 15.
        for (int lv = 0; lv < 17; lv++) begin
            ready_to_play();
            for (int i = 0; i < DOTS; i++) cyc(0, 0, 0, '0, 1);
            ticks(D_FR);
        end
        chk("sat_score", int'(score), SMAX);
        chk("wrap_level", int'(level), 1);
        $display("txn saturation/wrap: score=%0d level=%0d", score, level);

        for (int n = 0; n < 20000; n++) begin
            logic [N_GH-1:0] gh;
            gh = ($urandom_range(0, 39) == 0) ? N_GH'($urandom_range(1, 7)) : '0;
            cyc(($urandom_range(0, 1999) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0), gh, ($urandom_range(0, 3) == 0));
        end
        $display("txn random play done: state=%0d level=%0d", state, level);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
